// File: rtl/board_arbiter_pkg.sv
// Shared battleship definitions: cell/result/state encodings, ship count, address helper.
package board_arbiter_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_SHIP  = 2'd1,
    CELL_HIT   = 2'd2,
    CELL_MISS  = 2'd3
  } cell_e;

  typedef enum logic [1:0] {
    RES_MISS    = 2'd0,
    RES_HIT     = 2'd1,
    RES_REPEAT  = 2'd2,
    RES_INVALID = 2'd3
  } result_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DISP_RD   = 3'd1,
    ST_FIRE_RD   = 3'd2,
    ST_FIRE_EVAL = 3'd3,
    ST_FIRE_RSP  = 3'd4
  } state_e;

  localparam int SHIP_CELLS = 17;

  function automatic int unsigned cell_index(input logic [3:0] row, input logic [3:0] col,
                                             input int unsigned cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/board_arbiter_rr.sv
// Two-requester round-robin grant; the pointer flips on every granted fire.
module rr_arb2 (
  input  logic clk_vga,
  input  logic rst_n,
  input  logic req1,
  input  logic req2,
  input  logic advance,
  output logic grant,
  output logic grant_sel
);

  logic ptr;  // 0 = P1 has priority, 1 = P2

  assign grant     = req1 | req2;
  assign grant_sel = (req1 && req2) ? ptr : req2;

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/board_arbiter.sv
// Battleship board arbiter: shares one single-port board RAM between renderer and two shooters.
// Optional hit counters / game-over tracking enabled by BOARD_ARBITER_STATS_EN.
//
// state        | meaning
// ST_IDLE      | arbitrate: display first, then round-robin fire
// ST_DISP_RD   | display data returned, disp_valid pulse
// ST_FIRE_RD   | read of target cell issued
// ST_FIRE_EVAL | evaluate cell, write HIT/MISS when applicable
// ST_FIRE_RSP  | ack pulse to shooter with fire_result
module board_arbiter
  import board_arbiter_pkg::*;
#(
  parameter int ROWS       = 10,
  parameter int COLS       = 10,
  parameter int SHIP_CELLS = board_arbiter_pkg::SHIP_CELLS,
  localparam int IW = $clog2(ROWS * COLS),
  localparam int AW = IW + 1
) (
  input  logic          clk_vga,
  input  logic          rst_n,
  input  logic          disp_req,
  input  logic          disp_board,
  input  logic [3:0]    disp_row,
  input  logic [3:0]    disp_col,
  output logic          disp_valid,
  output logic [1:0]    disp_cell,
  input  logic          p1_fire_req,
  input  logic          p2_fire_req,
  input  logic [3:0]    p1_row,
  input  logic [3:0]    p1_col,
  input  logic [3:0]    p2_row,
  input  logic [3:0]    p2_col,
  output logic          p1_ack,
  output logic          p2_ack,
  output logic [1:0]    fire_result,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [1:0]    mem_wdata,
  input  logic [1:0]    mem_rdata,
  output logic [4:0]    p1_hits,
  output logic [4:0]    p2_hits,
  output logic          game_over,
  output logic          winner
);

  localparam logic [4:0] ROWS_LIM = 5'(ROWS);
  localparam logic [4:0] COLS_LIM = 5'(COLS);

  state_e        state_q, state_d;
  logic          run_q;
  logic          board_q;
  logic [IW-1:0] idx_q;
  logic          shooter_q;
  result_e       res_q, eval_res;
  logic          grant, grant_sel, advance;
  logic [3:0]    g_row, g_col;
  logic [IW-1:0] g_idx, d_idx;
  logic          fire_ok;
  logic          game_over_i;

  rr_arb2 u_rr (
    .clk_vga   (clk_vga),
    .rst_n     (rst_n),
    .req1      (p1_fire_req),
    .req2      (p2_fire_req),
    .advance   (advance),
    .grant     (grant),
    .grant_sel (grant_sel)
  );

  assign g_row   = grant_sel ? p2_row : p1_row;
  assign g_col   = grant_sel ? p2_col : p1_col;
  assign g_idx   = IW'(cell_index(g_row, g_col, COLS));
  assign d_idx   = IW'(cell_index(disp_row, disp_col, COLS));
  assign fire_ok = ({1'b0, g_row} < ROWS_LIM) && ({1'b0, g_col} < COLS_LIM) && !game_over_i;
  // run_q holds the arbiter quiet for the first cycle after reset release, keeping mem_addr at 0 in reset
  assign advance = (state_q == ST_IDLE) && run_q && !disp_req && grant;

  always_comb begin
    state_d     = state_q;
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    disp_valid  = 1'b0;
    disp_cell   = '0;
    p1_ack      = 1'b0;
    p2_ack      = 1'b0;
    fire_result = '0;
    eval_res    = RES_REPEAT;
    case (state_q)
      ST_IDLE: begin
        if (run_q) begin
          if (disp_req) begin
            mem_addr = {disp_board, d_idx};
            state_d  = ST_DISP_RD;
          end else if (grant) begin
            state_d = fire_ok ? ST_FIRE_RD : ST_FIRE_RSP;
          end
        end
      end
      ST_DISP_RD: begin
        disp_valid = 1'b1;
        disp_cell  = mem_rdata;
        state_d    = ST_IDLE;
      end
      ST_FIRE_RD: begin
        mem_addr = {board_q, idx_q};
        state_d  = ST_FIRE_EVAL;
      end
      ST_FIRE_EVAL: begin
        mem_addr = {board_q, idx_q};
        if (mem_rdata == CELL_SHIP) begin
          mem_we    = 1'b1;
          mem_wdata = CELL_HIT;
          eval_res  = RES_HIT;
        end else if (mem_rdata == CELL_EMPTY) begin
          mem_we    = 1'b1;
          mem_wdata = CELL_MISS;
          eval_res  = RES_MISS;
        end
        state_d = ST_FIRE_RSP;
      end
      ST_FIRE_RSP: begin
        p1_ack      = !shooter_q;
        p2_ack      = shooter_q;
        fire_result = res_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      run_q     <= 1'b0;
      board_q   <= 1'b0;
      idx_q     <= '0;
      shooter_q <= 1'b0;
      res_q     <= RES_MISS;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      if (advance) begin
        shooter_q <= grant_sel;
        board_q   <= ~grant_sel;  // P1 shoots at board 1, P2 at board 0
        idx_q     <= g_idx;
        if (!fire_ok) res_q <= RES_INVALID;
      end
      if (state_q == ST_FIRE_EVAL) res_q <= eval_res;
    end
  end

`ifdef BOARD_ARBITER_STATS_EN
  localparam logic [4:0] SC = 5'(SHIP_CELLS);

  logic [4:0] p1_hits_q, p2_hits_q;
  logic       go_q, win_q;
  logic       hit_ev;

  assign hit_ev = (state_q == ST_FIRE_EVAL) && (eval_res == RES_HIT);

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      p1_hits_q <= '0;
      p2_hits_q <= '0;
      go_q      <= 1'b0;
      win_q     <= 1'b0;
    end else if (hit_ev) begin
      if (!shooter_q) begin
        if (p1_hits_q < SC) p1_hits_q <= p1_hits_q + 5'd1;
        if (p1_hits_q == SC - 5'd1 && !go_q) begin
          go_q  <= 1'b1;
          win_q <= 1'b0;
        end
      end else begin
        if (p2_hits_q < SC) p2_hits_q <= p2_hits_q + 5'd1;
        if (p2_hits_q == SC - 5'd1 && !go_q) begin
          go_q  <= 1'b1;
          win_q <= 1'b1;
        end
      end
    end
  end

  assign p1_hits     = p1_hits_q;
  assign p2_hits     = p2_hits_q;
  assign game_over   = go_q;
  assign winner      = win_q;
  assign game_over_i = go_q;
`else
  assign p1_hits     = '0;
  assign p2_hits     = '0;
  assign game_over   = 1'b0;
  assign winner      = 1'b0;
  assign game_over_i = 1'b0;
`endif

endmodule
